// File: rtl/pin_pattern_controller_if.sv
// Command channel for pin_pattern_controller: opcode, pin mask and cycle argument.
// A command transfers on a rising clk edge where cmd_valid && cmd_ready; the master holds op/mask/arg stable while cmd_valid is high.
interface pin_pattern_controller_if #(
  parameter int N_PINS = 64,
  parameter int CNT_W  = 16
);
  logic              cmd_valid;
  logic              cmd_ready;
  logic [2:0]        cmd_op;
  logic [N_PINS-1:0] cmd_mask;
  logic [CNT_W-1:0]  cmd_arg;

  modport master (output cmd_valid, cmd_op, cmd_mask, cmd_arg, input cmd_ready);
  modport slave  (input cmd_valid, cmd_op, cmd_mask, cmd_arg, output cmd_ready);
endinterface

// File: rtl/pin_pattern_controller.sv
// Drives N_PINS pins from a base register with one-shot pulse and shared blink overlays.
// Optional macro PIN_POLARITY_EN adds a polarity_mask input that inverts the registered pins.
module pin_pattern_controller #(
  parameter int N_PINS = 64,
  parameter int CNT_W  = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  pin_pattern_controller_if.slave  cmd,
`ifdef PIN_POLARITY_EN
  input  logic [N_PINS-1:0]        polarity_mask,
`endif
  output logic                     busy,
  output logic                     blink_active,
  output logic [N_PINS-1:0]        output_pins,
  output logic                     state_dbg
);

  localparam logic [2:0] OP_SET         = 3'd1;
  localparam logic [2:0] OP_CLEAR       = 3'd2;
  localparam logic [2:0] OP_TOGGLE      = 3'd3;
  localparam logic [2:0] OP_PULSE       = 3'd4;
  localparam logic [2:0] OP_BLINK_START = 3'd5;
  localparam logic [2:0] OP_BLINK_STOP  = 3'd6;
  localparam logic [2:0] OP_LOAD        = 3'd7;

  typedef enum logic {S_IDLE = 1'b0, S_PULSE = 1'b1} state_t;

  state_t            state, state_nx;
  logic [N_PINS-1:0] base, base_nx;
  logic [N_PINS-1:0] pulse_mask, pulse_mask_nx;
  logic [CNT_W-1:0]  pulse_cnt, pulse_cnt_nx;
  logic [N_PINS-1:0] blink_mask, blink_mask_nx;
  logic [CNT_W-1:0]  half, half_nx;
  logic [CNT_W-1:0]  blink_cnt, blink_cnt_nx;
  logic              phase, phase_nx;
  logic              accept;
  logic [CNT_W-1:0]  arg_eff;
  logic [N_PINS-1:0] pins_nx;
  logic [N_PINS-1:0] pins_out_nx;

  assign cmd.cmd_ready = (state == S_IDLE);
  assign state_dbg     = (state == S_PULSE);

  always_comb begin
    state_nx      = state;
    base_nx       = base;
    pulse_mask_nx = pulse_mask;
    pulse_cnt_nx  = pulse_cnt;
    blink_mask_nx = blink_mask;
    half_nx       = half;
    blink_cnt_nx  = blink_cnt;
    phase_nx      = phase;
    accept        = cmd.cmd_valid && (state == S_IDLE);
    // A zero argument still gives a one-cycle pulse / half-period.
    arg_eff       = (cmd.cmd_arg == '0) ? CNT_W'(1) : cmd.cmd_arg;

    if (accept) begin
      case (cmd.cmd_op)
        OP_SET:        base_nx       = base | cmd.cmd_mask;
        OP_CLEAR:      base_nx       = base & ~cmd.cmd_mask;
        OP_TOGGLE:     base_nx       = base ^ cmd.cmd_mask;
        OP_LOAD:       base_nx       = cmd.cmd_mask;
        OP_BLINK_STOP: blink_mask_nx = blink_mask & ~cmd.cmd_mask;
        OP_BLINK_START: begin
          blink_mask_nx = blink_mask | cmd.cmd_mask;
          half_nx       = arg_eff;
        end
        default: ;
      endcase
    end

    case (state)
      S_IDLE: begin
        if (accept && cmd.cmd_op == OP_PULSE) begin
          pulse_mask_nx = cmd.cmd_mask;
          pulse_cnt_nx  = arg_eff;
          state_nx      = S_PULSE;
        end
      end
      S_PULSE: begin
        if (pulse_cnt == CNT_W'(1)) begin
          pulse_mask_nx = '0;
          pulse_cnt_nx  = '0;
          state_nx      = S_IDLE;
        end else begin
          pulse_cnt_nx = pulse_cnt - CNT_W'(1);
        end
      end
      default: state_nx = S_IDLE;
    endcase

    // Blink restarts in the "on" phase; otherwise it free-runs whenever any pin blinks.
    if (accept && cmd.cmd_op == OP_BLINK_START) begin
      blink_cnt_nx = '0;
      phase_nx     = 1'b1;
    end else if (blink_mask != '0) begin
      if (blink_cnt == half - CNT_W'(1)) begin
        blink_cnt_nx = '0;
        phase_nx     = ~phase;
      end else begin
        blink_cnt_nx = blink_cnt + CNT_W'(1);
      end
    end
    if (blink_mask_nx == '0) begin
      blink_cnt_nx = '0;
      phase_nx     = 1'b0;
    end

    pins_nx = base_nx ^ pulse_mask_nx ^ (phase_nx ? blink_mask_nx : '0);
  end

`ifdef PIN_POLARITY_EN
  assign pins_out_nx = pins_nx ^ polarity_mask;
`else
  assign pins_out_nx = pins_nx;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= S_IDLE;
      base         <= '0;
      pulse_mask   <= '0;
      pulse_cnt    <= '0;
      blink_mask   <= '0;
      half         <= '0;
      blink_cnt    <= '0;
      phase        <= 1'b0;
      busy         <= 1'b0;
      blink_active <= 1'b0;
      output_pins  <= '0;
    end else begin
      state        <= state_nx;
      base         <= base_nx;
      pulse_mask   <= pulse_mask_nx;
      pulse_cnt    <= pulse_cnt_nx;
      blink_mask   <= blink_mask_nx;
      half         <= half_nx;
      blink_cnt    <= blink_cnt_nx;
      phase        <= phase_nx;
      busy         <= (state_nx == S_PULSE);
      blink_active <= (blink_mask_nx != '0);
      output_pins  <= pins_out_nx;
    end
  end

endmodule

// File: tb/tb_pin_pattern_controller.sv
// Randomized and directed bench for pin_pattern_controller against a cycle-count reference model.
module tb_pin_pattern_controller;
  localparam int N_PINS = 64;
  localparam int CNT_W  = 16;

  localparam logic [2:0] OP_NOP = 3'd0, OP_SET = 3'd1, OP_CLEAR = 3'd2, OP_TOGGLE = 3'd3;
  localparam logic [2:0] OP_PULSE = 3'd4, OP_BSTART = 3'd5, OP_BSTOP = 3'd6, OP_LOAD = 3'd7;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic              busy;
  logic              blink_active;
  logic [N_PINS-1:0] output_pins;
  logic              state_dbg;

  pin_pattern_controller_if #(.N_PINS(N_PINS), .CNT_W(CNT_W)) cmd_if ();

`ifdef PIN_POLARITY_EN
  logic [N_PINS-1:0] polarity_mask = '0;
`endif

  pin_pattern_controller #(.N_PINS(N_PINS), .CNT_W(CNT_W)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cmd          (cmd_if),
`ifdef PIN_POLARITY_EN
    .polarity_mask(polarity_mask),
`endif
    .busy         (busy),
    .blink_active (blink_active),
    .output_pins  (output_pins),
    .state_dbg    (state_dbg)
  );

  // clock / reset
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  logic [N_PINS-1:0] exp_q[$];

  // reference model: pulse as remaining cycles, blink as age since start
  logic [N_PINS-1:0] m_base, m_pmask, m_bmask;
  int m_left, m_half, m_age;

  task automatic check(input string tag, input logic [N_PINS-1:0] got, input logic [N_PINS-1:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_base = '0; m_pmask = '0; m_bmask = '0;
    m_left = 0; m_half = 1; m_age = 0;
  endtask

  function automatic logic [N_PINS-1:0] model_pins();
    logic [N_PINS-1:0] r;
    r = m_base;
    if (m_left > 0) r = r ^ m_pmask;
    if (m_bmask != '0 && ((m_age / m_half) % 2) == 0) r = r ^ m_bmask;
    return r;
  endfunction

  task automatic model_edge(input logic v, input logic [2:0] op,
                            input logic [N_PINS-1:0] m, input logic [CNT_W-1:0] a);
    bit acc;
    int eff;
    acc = v && (m_left == 0);
    eff = (a == 0) ? 1 : int'(a);
    if (m_left > 0) m_left--;
    if (m_bmask != '0) m_age++;
    if (acc) begin
      case (op)
        OP_SET:    m_base = m_base | m;
        OP_CLEAR:  m_base = m_base & ~m;
        OP_TOGGLE: m_base = m_base ^ m;
        OP_LOAD:   m_base = m;
        OP_PULSE:  begin m_pmask = m; m_left = eff; end
        OP_BSTART: begin m_bmask = m_bmask | m; m_half = eff; m_age = 0; end
        OP_BSTOP:  m_bmask = m_bmask & ~m;
        default: ;
      endcase
    end
    exp_q.push_back(model_pins());
  endtask

  // driver: one clock cycle with the given command, then scoreboard compare
  task automatic step(input logic v, input logic [2:0] op,
                      input logic [N_PINS-1:0] m, input logic [CNT_W-1:0] a);
    logic [N_PINS-1:0] exp_pins;
    @(negedge clk);
    cmd_if.cmd_valid = v;
    cmd_if.cmd_op    = op;
    cmd_if.cmd_mask  = m;
    cmd_if.cmd_arg   = a;
    @(posedge clk);
    model_edge(v, op, m, a);
    #1;
    exp_pins = exp_q.pop_front();
    check("pins",  output_pins, exp_pins);
    check("busy",  N_PINS'(busy), N_PINS'(m_left > 0));
    check("state", N_PINS'(state_dbg), N_PINS'(m_left > 0));
    check("ready", N_PINS'(cmd_if.cmd_ready), N_PINS'(m_left == 0));
    check("blink_active", N_PINS'(blink_active), N_PINS'(m_bmask != '0));
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, OP_NOP, '0, '0);
  endtask

  task automatic async_reset();
    #2 rst_n = 1'b0;
    #1;
    check("rst_pins",  output_pins, '0);
    check("rst_busy",  N_PINS'(busy), '0);
    check("rst_blink", N_PINS'(blink_active), '0);
    check("rst_ready", N_PINS'(cmd_if.cmd_ready), N_PINS'(1));
    model_reset();
    exp_q.delete();
    cmd_if.cmd_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    logic [N_PINS-1:0] rm;
    logic [2:0] rop;
    cmd_if.cmd_valid = 1'b0;
    cmd_if.cmd_op    = OP_NOP;
    cmd_if.cmd_mask  = '0;
    cmd_if.cmd_arg   = '0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    check("reset_pins",  output_pins, '0);
    check("reset_busy",  N_PINS'(busy), '0);
    check("reset_ready", N_PINS'(cmd_if.cmd_ready), N_PINS'(1));
    @(negedge clk);
    rst_n = 1'b1;

    // toggles including the top pin
    step(1'b1, OP_TOGGLE, 64'h1, '0);                 check("tog_b0",  output_pins, 64'h1);
    step(1'b1, OP_TOGGLE, 64'h8, '0);                 check("tog_b3",  output_pins, 64'h9);
    step(1'b1, OP_TOGGLE, 64'h1, '0);                 check("tog_b0b", output_pins, 64'h8);
    step(1'b1, OP_TOGGLE, 64'h8000_0000_0000_0000, '0); check("tog_b63", output_pins, 64'h8000_0000_0000_0008);
    step(1'b1, OP_TOGGLE, 64'h8000_0000_0000_0000, '0); check("tog_b63b", output_pins, 64'h8);

    // five-cycle pulse over a loaded base
    step(1'b1, OP_LOAD, 64'hF0, '0);                  check("load", output_pins, 64'hF0);
    step(1'b1, OP_PULSE, 64'h0F, 16'd5);              check("pulse_c0", output_pins, 64'hFF);
    for (int i = 1; i < 5; i++) begin
      step(1'b0, OP_NOP, '0, '0);
      check("pulse_on", output_pins, 64'hFF);
      check("pulse_rdy", N_PINS'(cmd_if.cmd_ready), '0);
    end
    step(1'b0, OP_NOP, '0, '0);                       check("pulse_end", output_pins, 64'hF0);
    check("pulse_end_rdy", N_PINS'(cmd_if.cmd_ready), N_PINS'(1));

    // blink half-period 3 on bit8
    step(1'b1, OP_BSTART, 64'h100, 16'd3);            check("blink_b8_0", N_PINS'(output_pins[8]), N_PINS'(1));
    for (int i = 1; i < 12; i++) begin
      step(1'b0, OP_NOP, '0, '0);
      check("blink_b8", N_PINS'(output_pins[8]), N_PINS'(((i / 3) % 2) == 0));
    end
    step(1'b1, OP_BSTOP, 64'h100, '0);
    check("bstop_b8", N_PINS'(output_pins[8]), '0);
    check("bstop_act", N_PINS'(blink_active), '0);

    // zero-length pulse and a SET held through busy
    step(1'b1, OP_PULSE, 64'h1, 16'd0);               check("p0_on", output_pins, 64'hF1);
    step(1'b1, OP_SET, 64'h2, '0);                    check("p0_off", output_pins, 64'hF0);
    step(1'b1, OP_SET, 64'h2, '0);                    check("held_set", output_pins, 64'hF2);

    // blink and base overlap on bit2
    step(1'b1, OP_LOAD, 64'h0, '0);
    step(1'b1, OP_BSTART, 64'h4, 16'd2);              check("ov_0", output_pins, 64'h4);
    step(1'b1, OP_SET, 64'h4, '0);                    check("ov_1", output_pins, 64'h0);
    step(1'b0, OP_NOP, '0, '0);                       check("ov_2", output_pins, 64'h4);
    idle(6);
    step(1'b1, OP_BSTOP, 64'h4, '0);

    // reset in the middle of a pulse and a blink
    step(1'b1, OP_BSTART, 64'h10, 16'd4);
    step(1'b1, OP_PULSE, 64'hFF, 16'd20);
    idle(3);
    async_reset();
    idle(30);
    check("post_rst_pins", output_pins, '0);
    check("post_rst_ready", N_PINS'(cmd_if.cmd_ready), N_PINS'(1));

    // randomized traffic
    for (int i = 0; i < 600; i++) begin
      rop = 3'($urandom_range(0, 7));
      rm  = {$urandom(), $urandom()};
      if ($urandom_range(0, 1) == 0) rm = rm & {$urandom(), $urandom()};
      step($urandom_range(0, 3) != 0, rop, rm, CNT_W'($urandom_range(0, 6)));
      if (i == 300) begin
        async_reset();
      end
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/pin_pattern_controller.md
Name: pin_pattern_controller

Overview:
Parametrised successor to the 64-bit toggle-only pin controller. It drives N_PINS output pins from a base register and adds two timed overlays: a one-shot pulse engine and a shared blink generator. Commands arrive on a valid/ready interface. The block sits between the test-bench command decoder and the board I/O pins.

Parameters:
N_PINS, 64, number of output pins (1..128)
CNT_W, 16, width of pulse-length and blink half-period counters

Ports:
clk  input  1  system clock; all logic rising-edge
rst_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command this cycle
cmd_op  input  3  opcode (see Behaviour)
cmd_mask  input  N_PINS  pins affected by the command
cmd_arg  input  CNT_W  pulse length or blink half-period, in clk cycles
busy  output  1  pulse engine active
blink_active  output  1  blink_mask non-zero
output_pins  output  N_PINS  registered pin outputs

Behaviour:
- Interface: one clock (clk); reset rst_n is asynchronous, active-low.
- Reset values:
  - base, pulse_mask, blink_mask, blink phase, all counters = 0.
  - output_pins = 0, busy = 0, blink_active = 0.
  - cmd_ready = 1 once rst_n is deasserted.
  - FSM = IDLE.
- Accept rule: a command is accepted on a rising edge with cmd_valid && cmd_ready. Its effect is visible on output_pins immediately after that edge (registered output, one-edge latency).
- Opcodes:
  - 0 NOP
  - 1 SET: base |= mask
  - 2 CLEAR: base &= ~mask
  - 3 TOGGLE: base ^= mask
  - 4 PULSE
  - 5 BLINK_START
  - 6 BLINK_STOP: blink_mask &= ~mask
  - 7 LOAD: base = mask
- Output: output_pins = base ^ (busy ? pulse_mask : 0) ^ (phase ? blink_mask : 0).
- FSM IDLE:
  - cmd_ready = 1.
  - PULSE accepted: pulse_mask = mask, pulse_cnt = max(cmd_arg, 1), go to PULSE.
- FSM PULSE:
  - cmd_ready = 0, busy = 1.
  - pulse_cnt decrements each edge.
  - On the edge where pulse_cnt == 1: busy drops, pulse_mask clears, go to IDLE, cmd_ready = 1.
  - Pins therefore stay inverted for exactly max(arg, 1) cycles.
- Blink generator:
  - Runs in both FSM states.
  - BLINK_START: blink_mask |= mask, half = max(cmd_arg, 1), blink_cnt = 0, phase = 1.
  - Every edge while blink_mask != 0: blink_cnt++. When blink_cnt == half-1, blink_cnt = 0 and phase toggles.
  - When blink_mask becomes 0 (including via BLINK_STOP): phase = 0, blink_cnt = 0.
  - blink_active = (blink_mask != 0), registered.
- Overlapping overlays: the pulse and blink overlays XOR onto base independently. A pin may be in base, pulse and blink at once; the result is the XOR of all three.
- Width rules:
  - Mask bits above N_PINS do not exist.
  - Counters wrap only as described; cmd_arg = 0 is treated as 1 for PULSE and BLINK_START.
- Reset mid-pulse or mid-blink: all state returns to reset values immediately (asynchronous). No residual toggle occurs after rst_n rises.
- Commands are not accepted while busy. cmd_valid may be held; it is accepted on the edge after busy clears.

Optional Feature:
PIN_POLARITY_EN
- Defined:
  - Adds input port polarity_mask [N_PINS-1:0].
  - output_pins = (normal result) ^ polarity_mask, registered, so a change in polarity_mask appears one edge later.
  - Reset value of output_pins becomes 0 until the first edge after reset, then polarity_mask.
- Undefined: port absent, no inversion.

Test Plan:
- Reset, then TOGGLE mask=bit0, then TOGGLE bit3, TOGGLE bit0, TOGGLE bit63, TOGGLE bit63 -> output_pins = 0x1, 0x9, 0x8, 0x8000_0000_0000_0008, 0x8.
- LOAD 0xF0, PULSE mask=0x0F arg=5 -> output_pins = 0xFF for exactly 5 cycles, busy = 1, cmd_ready = 0; then 0xF0, cmd_ready = 1.
- BLINK_START mask=0x100 arg=3 -> bit8 = 1 for 3 cycles, 0 for 3 cycles, repeating; BLINK_STOP 0x100 -> bit8 = 0, blink_active = 0 next edge.
- PULSE arg=0 -> one-cycle inversion. A SET held on cmd_valid during the pulse is accepted on the first cycle after busy clears.
- Blink bit2 (half=2), SET bit2 -> bit2 shows the inverted blink pattern (XOR with base).
- Assert rst_n = 0 mid-pulse and mid-blink -> output_pins = 0 asynchronously; after release output_pins stays 0, cmd_ready = 1.
